// File: rtl/recovery_rf_pkg.sv
// rtl/recovery_rf_pkg.sv - shared types and Hsiao SECDED helpers for the recovery register file
package recovery_rf_pkg;

    typedef enum logic [1:0] {
        SCRUB_IDLE,
        SCRUB_WAIT,
        SCRUB_CHECK,
        SCRUB_FIX
    } scrub_state_e;

    // Smallest check-bit count whose odd-weight (>=3) columns cover k data bits
    function automatic int unsigned ecc_check_bits(input int unsigned k);
        int unsigned r;
        r = 2;
        while (((32'd1 << (r - 1)) - r) < k) r = r + 1;
        return r;
    endfunction

    // Stored word width: data plus check bits when protected
    function automatic int unsigned enc_width(input int unsigned k, input bit ecc);
        return ecc ? k + ecc_check_bits(k) : k;
    endfunction

    // H-matrix column for data bit idx: the idx-th odd-weight (>=3) r-bit value
    function automatic logic [31:0] hsiao_col(input int unsigned r, input int unsigned idx);
        int unsigned n;
        n = 0;
        for (int unsigned v = 1; v < (32'd1 << r); v++) begin
            if ($countones(v) >= 3 && ($countones(v) % 2) == 1) begin
                if (n == idx) return v;
                n = n + 1;
            end
        end
        return 32'd0;
    endfunction

endpackage

// File: rtl/hsiao_ecc_dec.sv
// rtl/hsiao_ecc_dec.sv - Hsiao SECDED decoder with single-bit correction
module hsiao_ecc_dec
    import recovery_rf_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    localparam int unsigned R = ecc_check_bits(DataWidth)
) (
    input  logic [DataWidth+R-1:0] cw_i,
    output logic [DataWidth-1:0]   data_o,
    output logic                   err_corr_o,
    output logic                   err_uncorr_o
);

    logic [R-1:0]         col [DataWidth];
    logic [R-1:0]         syn;
    logic [DataWidth-1:0] flip;

    for (genvar i = 0; i < DataWidth; i++) begin : g_col
        localparam logic [31:0] Col = hsiao_col(R, i);
        assign col[i]  = Col[R-1:0];
        assign flip[i] = (syn == col[i]);
    end

    // Syndrome is stored check bits against recomputed parity
    always_comb begin
        syn = cw_i[DataWidth +: R];
        for (int i = 0; i < DataWidth; i++) begin
            if (cw_i[i]) syn = syn ^ col[i];
        end
    end

    // Odd syndrome naming a data column or a single check bit is correctable;
    // anything else non-zero (even weight or unused odd column) is not
    assign data_o       = cw_i[DataWidth-1:0] ^ flip;
    assign err_corr_o   = (^syn) && ((|flip) || $onehot(syn));
    assign err_uncorr_o = (|syn) && !err_corr_o;

endmodule

// File: rtl/hsiao_ecc_enc.sv
// rtl/hsiao_ecc_enc.sv - Hsiao SECDED encoder, codeword = {check, data}
module hsiao_ecc_enc
    import recovery_rf_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    localparam int unsigned R = ecc_check_bits(DataWidth)
) (
    input  logic [DataWidth-1:0]   data_i,
    output logic [DataWidth+R-1:0] cw_o
);

    logic [R-1:0] col [DataWidth];
    logic [R-1:0] chk;

    for (genvar i = 0; i < DataWidth; i++) begin : g_col
        localparam logic [31:0] Col = hsiao_col(R, i);
        assign col[i] = Col[R-1:0];
    end

    // Check bits are the XOR of the columns of every set data bit
    always_comb begin
        chk = '0;
        for (int i = 0; i < DataWidth; i++) begin
            if (data_i[i]) chk = chk ^ col[i];
        end
    end

    assign cw_o = {chk, data_i};

endmodule

// File: rtl/recovery_rf_scrubber.sv
// rtl/recovery_rf_scrubber.sv - background scrub FSM, interval timer, index and error counters
module recovery_rf_scrubber
    import recovery_rf_pkg::*;
#(
    parameter int unsigned NumWords      = 32,
    parameter bit          ZeroReg       = 1'b1,
    parameter int unsigned ScrubInterval = 64,
    parameter int unsigned CntWidth      = 16,
    localparam int unsigned AddrWidth    = $clog2(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 scrub_en_i,
    input  logic                 err_corr_i,
    input  logic                 err_uncorr_i,
    input  logic                 conflict_i,
    input  logic                 cnt_clr_i,
    output logic [AddrWidth-1:0] idx_o,
    output logic                 fix_we_o,
    output logic                 scrub_fix_o,
    output logic [CntWidth-1:0]  corr_cnt_o,
    output logic [CntWidth-1:0]  uncorr_cnt_o
);

    localparam int unsigned          IntW     = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;
    localparam logic [IntW-1:0]      IntLoad  = IntW'(ScrubInterval - 1);
    localparam logic [AddrWidth-1:0] FirstIdx = ZeroReg ? AddrWidth'(1) : AddrWidth'(0);
    localparam logic [AddrWidth-1:0] LastIdx  = AddrWidth'(NumWords - 1);

    scrub_state_e         state;
    logic [IntW-1:0]      wait_cnt;
    logic [AddrWidth-1:0] idx_next;
    logic                 check_now;

    assign idx_next  = (idx_o == LastIdx) ? FirstIdx : idx_o + 1'b1;
    assign check_now = (state == SCRUB_CHECK) && scrub_en_i;
    // A functional write or injection on the same word this cycle cancels the repair
    assign fix_we_o  = (state == SCRUB_FIX) && scrub_en_i && !conflict_i && !rst_i;

    // Scrub sequencing: wait out the interval, check one word, repair if correctable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= SCRUB_IDLE;
            wait_cnt    <= '0;
            idx_o       <= FirstIdx;
            scrub_fix_o <= 1'b0;
        end else begin
            scrub_fix_o <= fix_we_o;
            if (!scrub_en_i) begin
                state <= SCRUB_IDLE;
            end else begin
                case (state)
                    SCRUB_IDLE: begin
                        state    <= SCRUB_WAIT;
                        wait_cnt <= IntLoad;
                    end
                    SCRUB_WAIT: begin
                        if (wait_cnt == '0) state <= SCRUB_CHECK;
                        else                wait_cnt <= wait_cnt - 1'b1;
                    end
                    SCRUB_CHECK: begin
                        if (err_corr_i) begin
                            state <= SCRUB_FIX;
                        end else begin
                            idx_o    <= idx_next;
                            wait_cnt <= IntLoad;
                            state    <= SCRUB_WAIT;
                        end
                    end
                    SCRUB_FIX: begin
                        idx_o    <= idx_next;
                        wait_cnt <= IntLoad;
                        state    <= SCRUB_WAIT;
                    end
                    default: state <= SCRUB_IDLE;
                endcase
            end
        end
    end

    // Saturating detection counters; clear beats a same-cycle detection
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            corr_cnt_o   <= '0;
            uncorr_cnt_o <= '0;
        end else if (check_now) begin
            if (err_corr_i && corr_cnt_o != '1)     corr_cnt_o   <= corr_cnt_o + 1'b1;
            if (err_uncorr_i && uncorr_cnt_o != '1) uncorr_cnt_o <= uncorr_cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/recovery_rf_scrub.sv
// rtl/recovery_rf_scrub.sv - multi-port SECDED register file with background scrubber
module recovery_rf_scrub
    import recovery_rf_pkg::*;
#(
    parameter int unsigned NumWords      = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumRead       = 3,
    parameter int unsigned NumWrite      = 2,
    parameter bit          EccEnabled    = 1'b1,
    parameter bit          ZeroReg       = 1'b1,
    parameter int unsigned ScrubInterval = 64,
    parameter int unsigned CntWidth      = 16,
    localparam int unsigned AddrWidth    = $clog2(NumWords),
    localparam int unsigned EncWidth     = enc_width(DataWidth, EccEnabled)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumRead-1:0][AddrWidth-1:0]   raddr_i,
    output logic [NumRead-1:0][DataWidth-1:0]   rdata_o,
    output logic [NumRead-1:0]                  rerr_corr_o,
    output logic [NumRead-1:0]                  rerr_uncorr_o,
    input  logic [NumWrite-1:0]                 we_i,
    input  logic [NumWrite-1:0][AddrWidth-1:0]  waddr_i,
    input  logic [NumWrite-1:0][DataWidth-1:0]  wdata_i,
    input  logic                                scrub_en_i,
    input  logic                                inj_en_i,
    input  logic [AddrWidth-1:0]                inj_addr_i,
    input  logic [EncWidth-1:0]                 inj_mask_i,
    input  logic                                cnt_clr_i,
    output logic [CntWidth-1:0]                 corr_cnt_o,
    output logic [CntWidth-1:0]                 uncorr_cnt_o,
    output logic                                scrub_fix_o
);

    typedef struct packed {
        logic                 we;
        logic [AddrWidth-1:0] addr;
        logic [EncWidth-1:0]  data;
    } wport_t;

    logic [EncWidth-1:0]  mem     [NumWords];
    logic [EncWidth-1:0]  mem_nxt [NumWords];
    wport_t               wport   [NumWrite];
    logic [AddrWidth-1:0] scrub_idx;
    logic                 fix_we;
    logic [EncWidth-1:0]  fix_cw;

    if (EccEnabled) begin : g_ecc
        logic [DataWidth-1:0] s_data;
        logic                 s_corr;
        logic                 s_uncorr;
        logic                 conflict;

        for (genvar p = 0; p < NumWrite; p++) begin : g_wr
            logic [EncWidth-1:0] cw;
            hsiao_ecc_enc #(.DataWidth(DataWidth)) u_enc (.data_i(wdata_i[p]), .cw_o(cw));
            assign wport[p] = '{we: we_i[p], addr: waddr_i[p], data: cw};
        end

        for (genvar r = 0; r < NumRead; r++) begin : g_rd
            logic [DataWidth-1:0] rd;
            logic                 rc;
            logic                 ru;
            logic                 zero_hit;
            hsiao_ecc_dec #(.DataWidth(DataWidth)) u_dec (
                .cw_i(mem[raddr_i[r]]), .data_o(rd), .err_corr_o(rc), .err_uncorr_o(ru)
            );
            assign zero_hit         = ZeroReg && (raddr_i[r] == '0);
            assign rdata_o[r]       = zero_hit ? '0 : rd;
            assign rerr_corr_o[r]   = rc && !zero_hit;
            assign rerr_uncorr_o[r] = ru && !zero_hit;
        end

        hsiao_ecc_dec #(.DataWidth(DataWidth)) u_scrub_dec (
            .cw_i(mem[scrub_idx]), .data_o(s_data), .err_corr_o(s_corr), .err_uncorr_o(s_uncorr)
        );
        hsiao_ecc_enc #(.DataWidth(DataWidth)) u_scrub_enc (.data_i(s_data), .cw_o(fix_cw));

        // Any functional write or injection aimed at the scrub word blocks its repair
        always_comb begin
            conflict = inj_en_i && (inj_addr_i == scrub_idx);
            for (int p = 0; p < NumWrite; p++) begin
                if (we_i[p] && waddr_i[p] == scrub_idx) conflict = 1'b1;
            end
        end

        recovery_rf_scrubber #(
            .NumWords(NumWords), .ZeroReg(ZeroReg),
            .ScrubInterval(ScrubInterval), .CntWidth(CntWidth)
        ) u_scrubber (
            .clk_i(clk_i), .rst_i(rst_i), .scrub_en_i(scrub_en_i),
            .err_corr_i(s_corr), .err_uncorr_i(s_uncorr), .conflict_i(conflict),
            .cnt_clr_i(cnt_clr_i), .idx_o(scrub_idx), .fix_we_o(fix_we),
            .scrub_fix_o(scrub_fix_o), .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o)
        );
    end else begin : g_plain
        for (genvar p = 0; p < NumWrite; p++) begin : g_wr
            assign wport[p] = '{we: we_i[p], addr: waddr_i[p], data: wdata_i[p]};
        end
        for (genvar r = 0; r < NumRead; r++) begin : g_rd
            assign rdata_o[r] = (ZeroReg && raddr_i[r] == '0) ? '0 : mem[raddr_i[r]];
        end
        assign rerr_corr_o   = '0;
        assign rerr_uncorr_o = '0;
        assign corr_cnt_o    = '0;
        assign uncorr_cnt_o  = '0;
        assign scrub_fix_o   = 1'b0;
        assign fix_we        = 1'b0;
        assign fix_cw        = '0;
        assign scrub_idx     = '0;
    end

    // Next word value: scrub fix, then writes (highest port last), then injection on top
    always_comb begin
        for (int w = 0; w < NumWords; w++) begin
            mem_nxt[w] = mem[w];
            if (fix_we && scrub_idx == AddrWidth'(w)) mem_nxt[w] = fix_cw;
            for (int p = 0; p < NumWrite; p++) begin
                if (wport[p].we && wport[p].addr == AddrWidth'(w)) mem_nxt[w] = wport[p].data;
            end
            if (inj_en_i && inj_addr_i == AddrWidth'(w)) mem_nxt[w] = mem_nxt[w] ^ inj_mask_i;
            if (ZeroReg && w == 0) mem_nxt[w] = '0;
        end
    end

    // Storage update; all-zero is the valid codeword of zero data
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < NumWords; w++) begin
            if (rst_i) mem[w] <= '0;
            else       mem[w] <= mem_nxt[w];
        end
    end

endmodule

// File: tb/tb_recovery_rf_scrub.sv
// tb/tb_recovery_rf_scrub.sv - scoreboard bench for recovery_rf_scrub
module tb_recovery_rf_scrub;
    import recovery_rf_pkg::*;

    localparam int unsigned NW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned NR  = 3;
    localparam int unsigned NWR = 2;
    localparam int unsigned AW  = 5;
    localparam int unsigned CW  = 4;
    localparam int unsigned EW  = enc_width(32, 1'b1);

    localparam int S_RDATA = 0;
    localparam int S_CORR  = 1;
    localparam int S_UNC   = 2;
    localparam int S_CCNT  = 3;
    localparam int S_UCNT  = 4;
    localparam int S_FIX   = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NR-1:0][AW-1:0]  raddr;
    logic [NR-1:0][DW-1:0]  rdata;
    logic [NR-1:0]          rcorr;
    logic [NR-1:0]          runcorr;
    logic [NWR-1:0]         we;
    logic [NWR-1:0][AW-1:0] waddr;
    logic [NWR-1:0][DW-1:0] wdata;
    logic                   scrub_en;
    logic                   inj_en;
    logic [AW-1:0]          inj_addr;
    logic [EW-1:0]          inj_mask;
    logic                   cnt_clr;
    logic [CW-1:0]          corr_cnt;
    logic [CW-1:0]          uncorr_cnt;
    logic                   scrub_fix;

    recovery_rf_scrub #(
        .NumWords(NW), .DataWidth(DW), .NumRead(NR), .NumWrite(NWR),
        .EccEnabled(1'b1), .ZeroReg(1'b1), .ScrubInterval(4), .CntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata),
        .rerr_corr_o(rcorr), .rerr_uncorr_o(runcorr), .we_i(we), .waddr_i(waddr),
        .wdata_i(wdata), .scrub_en_i(scrub_en), .inj_en_i(inj_en), .inj_addr_i(inj_addr),
        .inj_mask_i(inj_mask), .cnt_clr_i(cnt_clr), .corr_cnt_o(corr_cnt),
        .uncorr_cnt_o(uncorr_cnt), .scrub_fix_o(scrub_fix)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] got;
    int          n_vec    = 0;
    int          n_miss   = 0;
    int          fix_seen = 0;

    // Monitor: count fix pulses, then drain every expectation queued this cycle
    always @(negedge clk) begin
        if (scrub_fix === 1'b1) fix_seen = fix_seen + 1;
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            case (cur.sel)
                S_RDATA: got = rdata[cur.port];
                S_CORR:  got = 32'(rcorr[cur.port]);
                S_UNC:   got = 32'(runcorr[cur.port]);
                S_CCNT:  got = 32'(corr_cnt);
                S_UCNT:  got = 32'(uncorr_cnt);
                S_FIX:   got = 32'(fix_seen);
                default: got = 32'hFFFF_FFFF;
            endcase
            n_vec = n_vec + 1;
            if (got !== cur.exp) begin
                n_miss = n_miss + 1;
                $display("FAIL %s: got %h, expected %h", cur.name, got, cur.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int sel, input int port, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic read_chk(input string name, input int port, input int a,
                            input logic [31:0] d, input logic c, input logic u);
        raddr[port] = AW'(a);
        expect_val({name, "_data"}, S_RDATA, port, d);
        expect_val({name, "_corr"}, S_CORR, port, 32'(c));
        expect_val({name, "_uncorr"}, S_UNC, port, 32'(u));
    endtask

    task automatic do_reset();
        rst = 1'b1; we = '0; inj_en = 1'b0; scrub_en = 1'b0; cnt_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; raddr = '0; we = '0; waddr = '0; wdata = '0;
        scrub_en = 1'b0; inj_en = 1'b0; inj_addr = '0; inj_mask = '0; cnt_clr = 1'b0;
        do_reset();

        // Every word reads clean zero after reset
        for (int a = 0; a < NW; a += 3) begin
            for (int p = 0; p < NR; p++) read_chk("rst_word", p, (a + p) % NW, 32'h0, 1'b0, 1'b0);
            tick();
        end
        expect_val("rst_corr_cnt", S_CCNT, 0, 32'd0);
        expect_val("rst_uncorr_cnt", S_UCNT, 0, 32'd0);
        tick();

        // Same-address double write: higher port wins, no bypass in the write cycle
        we = 2'b11; waddr[0] = AW'(5); waddr[1] = AW'(5);
        wdata[0] = 32'hAAAA_0000; wdata[1] = 32'h5555_FFFF;
        read_chk("no_bypass", 0, 5, 32'h0, 1'b0, 1'b0);
        tick();
        we = '0;
        read_chk("port_prio", 0, 5, 32'h5555_FFFF, 1'b0, 1'b0);
        we[0] = 1'b1; waddr[0] = AW'(0); wdata[0] = 32'hDEAD_BEEF;
        tick();
        we = '0;
        read_chk("zero_reg", 1, 0, 32'h0, 1'b0, 1'b0);
        tick();

        // Single data-bit, double and single check-bit injections
        we[0] = 1'b1; waddr[0] = AW'(7); wdata[0] = 32'h1234_5678;
        tick();
        we = '0;
        inj_en = 1'b1; inj_addr = AW'(7); inj_mask = EW'(1) << 4;
        tick();
        inj_addr = AW'(9); inj_mask = (EW'(1) << 2) | (EW'(1) << 35);
        tick();
        inj_addr = AW'(11); inj_mask = EW'(1) << 33;
        tick();
        inj_en = 1'b0;
        read_chk("single_err", 0, 7, 32'h1234_5678, 1'b1, 1'b0);
        raddr[1] = AW'(9);
        expect_val("double_err_uncorr", S_UNC, 1, 32'd1);
        expect_val("double_err_corr", S_CORR, 1, 32'd0);
        read_chk("check_bit_err", 2, 11, 32'h0, 1'b1, 1'b0);
        tick();

        // Scrub pass over words 1..13: fixes 7 and 11, counts 9 as uncorrectable
        scrub_en = 1'b1;
        repeat (75) tick();
        scrub_en = 1'b0;
        expect_val("scrub_fix_count", S_FIX, 0, 32'd2);
        expect_val("scrub_corr_cnt", S_CCNT, 0, 32'd2);
        expect_val("scrub_uncorr_cnt", S_UCNT, 0, 32'd1);
        read_chk("after_fix7", 0, 7, 32'h1234_5678, 1'b0, 1'b0);
        read_chk("after_fix11", 2, 11, 32'h0, 1'b0, 1'b0);
        raddr[1] = AW'(9);
        expect_val("word9_still_bad", S_UNC, 1, 32'd1);
        tick();

        // Functional write to word 3 during its FIX cycle cancels the repair
        do_reset();
        inj_en = 1'b1; inj_addr = AW'(3); inj_mask = EW'(1);
        tick();
        inj_en = 1'b0; scrub_en = 1'b1;
        repeat (16) tick();
        we[1] = 1'b1; waddr[1] = AW'(3); wdata[1] = 32'hCAFE_F00D;
        tick();
        we = '0;
        read_chk("fix_abort", 0, 3, 32'hCAFE_F00D, 1'b0, 1'b0);
        expect_val("fix_abort_no_pulse", S_FIX, 0, 32'd2);
        expect_val("fix_abort_corr_cnt", S_CCNT, 0, 32'd1);
        scrub_en = 1'b0;
        tick();

        // Twenty correctable words saturate the 4-bit counter at 15
        do_reset();
        for (int w = 1; w <= 20; w++) begin
            inj_en = 1'b1; inj_addr = AW'(w); inj_mask = EW'(1) << w;
            tick();
        end
        inj_en = 1'b0; scrub_en = 1'b1;
        repeat (140) tick();
        scrub_en = 1'b0;
        expect_val("sat_corr_cnt", S_CCNT, 0, 32'd15);
        expect_val("sat_uncorr_cnt", S_UCNT, 0, 32'd0);
        expect_val("sat_fix_count", S_FIX, 0, 32'd22);
        read_chk("sat_word20", 0, 20, 32'h0, 1'b0, 1'b0);
        tick();

        // Clear wins over a detection in CHECK, then reset lands during FIX
        do_reset();
        inj_en = 1'b1; inj_addr = AW'(1); inj_mask = EW'(1);
        tick();
        inj_en = 1'b0; scrub_en = 1'b1;
        repeat (5) tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        expect_val("clr_beats_detect", S_CCNT, 0, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_val("rst_in_fix_no_pulse", S_FIX, 0, 32'd22);
        read_chk("rst_in_fix_word1", 0, 1, 32'h0, 1'b0, 1'b0);
        tick();
        expect_val("rst_in_fix_idle", S_FIX, 0, 32'd22);
        expect_val("rst_in_fix_corr_cnt", S_CCNT, 0, 32'd0);
        scrub_en = 1'b0;
        repeat (3) tick();

        if (sb.size() != 0) begin
            n_miss = n_miss + 1;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/recovery_rf_scrub.md
Name: recovery_rf_scrub

Overview:
- Next-generation flop-based register file for rapid-recovery cores, replacing fixed 3R/2W latch storage.
- Parametrised in depth, width and read/write port count; optional SECDED protection.
- Adds a background scrubber FSM that repairs correctable errors in place, per-read error flags, saturating error counters, and a codeword error-injection port for fault campaigns.
- Sits inside the HMR rapid-recovery unit as the architectural register backup/restore store.

Parameters:
- NumWords, 32, number of words; address width AddrWidth = $clog2(NumWords).
- DataWidth, 32, unprotected data width.
- NumRead, 3, read port count.
- NumWrite, 2, write port count.
- EccEnabled, 1, 1: store Hsiao SECDED codewords; 0: plain storage, scrubber and counters removed.
- ZeroReg, 1, 1: word 0 reads 0, ignores writes, is skipped by the scrubber.
- ScrubInterval, 64, idle cycles between scrub checks; must be ≥1.
- CntWidth, 16, error counter width.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset, synchronous, active-high.
- raddr_i, in, NumRead x AddrWidth, read addresses.
- rdata_o, out, NumRead x DataWidth, corrected read data, combinational.
- rerr_corr_o, out, NumRead, read saw a single-bit error (corrected).
- rerr_uncorr_o, out, NumRead, read saw an uncorrectable error.
- we_i, in, NumWrite, write enables.
- waddr_i, in, NumWrite x AddrWidth, write addresses.
- wdata_i, in, NumWrite x DataWidth, write data.
- scrub_en_i, in, 1, enable background scrubber.
- inj_en_i, in, 1, error-injection strobe.
- inj_addr_i, in, AddrWidth, word to corrupt.
- inj_mask_i, in, EncWidth, XOR mask applied to the stored codeword.
- cnt_clr_i, in, 1, clear error counters.
- corr_cnt_o, out, CntWidth, correctable errors found by the scrubber.
- uncorr_cnt_o, out, CntWidth, uncorrectable errors found by the scrubber.
- scrub_fix_o, out, 1, one-cycle pulse when the scrubber rewrites a word.

Behaviour:
Storage and reset
- EncWidth = DataWidth + SECDED check bits when EccEnabled, else DataWidth.
- rst_i (sampled on the clk_i edge) clears all words to the encoding of 0, counters to 0, FSM to IDLE, scrub index to the first index, scrub_fix_o to 0.
- Reset during any scrub state aborts it; no partial write.
- Error flags are 0 after reset because stored words are valid codewords.

Reads
- Combinational: rdata_o = decode(mem[raddr]).
- Word 0 returns 0 with clear flags when ZeroReg=1.

Writes
- Registered; data is visible to reads on the next cycle. No write-to-read bypass.
- Writes to word 0 are dropped when ZeroReg=1.
- If several ports write the same address in one cycle, the highest port index wins.

Injection
- On inj_en_i, next mem[inj_addr] = mem[inj_addr] XOR inj_mask_i.
- Injection is applied after functional writes in the same cycle; an injection to a word being written corrupts the new data.

Scrubber FSM (EccEnabled=1)
- IDLE: leave when scrub_en_i=1; interval counter loads ScrubInterval-1.
- WAIT: decrement the counter; go to CHECK at 0. Drop of scrub_en_i returns to IDLE from any state; scrub index is retained.
- CHECK: decode mem[idx].
  - Single-bit error: increment corr_cnt and go to FIX.
  - Double-bit error: increment uncorr_cnt, do not rewrite, advance idx, go to WAIT.
  - No error: advance idx, go to WAIT.
- FIX: write the corrected codeword and pulse scrub_fix_o. The fix is aborted (no pulse, no write) if any functional write or an injection targets idx this cycle; the functional write wins. Then advance idx and go to WAIT.
- Index advance: NumWords-1 wraps to 1 when ZeroReg=1, else to 0.

Counters
- Saturate at all-ones.
- cnt_clr_i has priority over a simultaneous increment.
- Counters count scrubber detections only, not read-port flags.

EccEnabled=0
- Flags, counters and scrub_fix_o are tied 0; injection still XORs the data.

Decomposition:
- Package recovery_rf_pkg holds the EncWidth function, the scrub FSM state enum, and the write-port struct (we/addr/data) parametrised by width.
- Sub-module recovery_rf_scrubber contains the FSM, interval counter, index and error counters.
- Encoders/decoders are instantiated from the existing hsiao_ecc_enc/hsiao_ecc_dec.

Test Plan:
- Reset, then read all words through 3 ports -> all rdata 0, all flags 0, counters 0.
- Port0 and port1 both write addr 5 (0xAAAA0000 / 0x5555FFFF) -> next cycle read addr 5 = 0x5555FFFF. Write 0xDEADBEEF to addr 0 -> reads 0.
- Write addr 7 = 0x12345678, inject single-bit mask at addr 7 -> rdata 0x12345678, rerr_corr=1. Scrub enabled with ScrubInterval=4 -> scrub_fix_o pulse, corr_cnt=1, later reads show rerr_corr=0.
- Inject a 2-bit mask at addr 9 -> rerr_uncorr=1. Scrub pass -> uncorr_cnt=1, no fix pulse, word still erroneous.
- Scrubber in FIX for addr 3 while port1 writes 0xCAFEF00D to addr 3 -> no scrub_fix_o, read = 0xCAFEF00D with clean flags.
- Preload corr_cnt to all-ones by repeated injections (CntWidth=4) -> holds 15. cnt_clr_i with a simultaneous detection -> 0. rst_i asserted in FIX -> no write, FSM IDLE.
